mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL provide port `clk`: in, 1 bit, sole clock; all state updates on the rising edge.
REQ-002 SHALL provide port `rst`: in, 1 bit, asynchronous active-low reset.
REQ-003 SHALL provide port `mul_start`: in, 1 bit, one-cycle request from execute.
REQ-004 SHALL provide port `mul_type`: in, 2 bits; 00 MULR, 01 MULI (unsigned), 10 MULSR, 11 MULSI (signed).
REQ-005 SHALL provide port `operand_a`: in, 32 bits, multiplicand.
REQ-006 SHALL provide port `operand_b`: in, 32 bits, multiplier (register value or sign-extended imm).
REQ-007 SHALL provide port `dest_reg`: in, 4 bits, writeback register index.
REQ-008 SHALL provide port `mul_busy`: out, 1 bit, high while not IDLE.
REQ-009 SHALL provide port `mul_release`: out, 1 bit, one-cycle completion strobe.
REQ-010 SHALL provide port `mul_result`: out, 32 bits, low 32 bits of product, valid only with `mul_release`.
REQ-011 SHALL provide port `mul_dest`: out, 4 bits, captured `dest_reg`, valid only with `mul_release`.
REQ-012 SHALL provide port `write_to_reg`: out, 1 bit, equal to `mul_release`.
REQ-013 SHALL provide port `flags_back`: out, 4 bits, NZCV, valid only with `mul_release`; execute ORs it into its flags.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE only, accept `mul_start=1`, capture operands, type and dest, clear the 64-bit accumulator and iteration counter, and go to RUN.
REQ-016 SHALL convert both operands to magnitudes at capture for signed types and record sign = a[31]^b[31]; unsigned types use raw operands and sign=0.
REQ-017 SHALL in RUN process one multiplier bit per cycle, LSB first: add the shifted multiplicand if the bit is 1, shift the multiplier right, increment the 5-bit counter.
REQ-018 SHALL leave RUN for DONE after iteration 31 completes (counter wrap 31->0), i.e. 32 RUN cycles.
REQ-019 SHALL in DONE apply 64-bit two's-complement negation if sign=1, assert `mul_release`/`write_to_reg` for exactly one cycle, drive `mul_result`/`mul_dest`/`flags_back`, then return to IDLE.
REQ-020 SHALL give a fixed latency (early exit disabled) of 33 edges: `mul_start` sampled on edge 0, `mul_release` high in the cycle after edge 33.
REQ-021 SHALL ignore `mul_start` in RUN and DONE: no queuing, no corruption of the in-flight operation.
REQ-022 SHALL drive `flags_back`=0000 for MULR/MULI.
REQ-023 SHALL, for MULSR/MULSI, set N=result[31], Z=(result==0), C=(upper 32 bits of magnitude product !=0), V=(64-bit signed product != sign-extension of result).
REQ-024 SHALL hold `mul_result`, `mul_dest` and `flags_back` at 0 whenever `mul_release`=0.

Reset
REQ-025 SHALL, on `rst` low at any time (including mid-RUN), force IDLE, clear accumulator, counter and captured fields, and drive all outputs to 0 without waiting for a clock edge.
REQ-026 SHALL, after `rst` deasserts, accept `mul_start` from the first rising edge.

Configuration
REQ-027 SHALL, with macro MUL_EARLY_EXIT_EN defined, go from RUN to DONE at the end of the first iteration that leaves the shifted multiplier zero, and go straight from IDLE to DONE when the captured multiplier magnitude is zero.
REQ-028 SHALL, without MUL_EARLY_EXIT_EN, always run exactly 32 RUN cycles; results and flags are identical in both builds.

Structure
REQ-029 SHALL place the `mul_type` encodings, FSM state encodings, MUL_ITER=32 and the NZCV bit positions in the shared CPU package used by execute.
REQ-030 SHALL remain a single module with no sub-module; sign fix-up and flag generation stay inline combinational logic.

Verification
REQ-031 SHALL cover: MULR a=7, b=6 -> `mul_result`=42, `flags_back`=0000, `mul_release` one cycle, 33 edges after start.
REQ-032 SHALL cover: MULSR a=0xFFFFFFFD, b=5 -> result 0xFFFFFFF1, flags 1000.
REQ-033 SHALL cover: MULSI a=0x00010000, b=0x00010000 -> result 0, flags 0111.
REQ-034 SHALL cover: `mul_start` pulsed at RUN cycle 10 with different operands -> ignored, original result 42 delivered; second pulse in DONE also ignored.
REQ-035 SHALL cover: `rst` low at RUN cycle 15 -> `mul_busy`=0, all outputs 0 immediately; a new start after release completes correctly.
REQ-036 SHALL cover, with MUL_EARLY_EXIT_EN: MULR a=5, b=1 -> release after 2 edges, result 5; b=0 -> release after 1 edge, result 0.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared CPU definitions for the iterative multiplier: operation encodings,
// FSM state encodings, iteration count and NZCV flag bit positions.
package mul_unit_pkg;

  localparam logic [1:0] MUL_R  = 2'b00;
  localparam logic [1:0] MUL_I  = 2'b01;
  localparam logic [1:0] MUL_SR = 2'b10;
  localparam logic [1:0] MUL_SI = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int MUL_ITER = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_unit.sv
// Iterative 32x32 shift-add multiplier with signed fix-up and NZCV flags.
// Optional MUL_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier is zero.
module mul_unit
  import mul_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_start,
  input  logic [1:0]  mul_type,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  dest_reg,
  output logic        mul_busy,
  output logic        mul_release,
  output logic [31:0] mul_result,
  output logic [3:0]  mul_dest,
  output logic        write_to_reg,
  output logic [3:0]  flags_back
);

  localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

  logic [1:0]  r_state;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic        r_signed;
  logic [3:0]  r_dest;

  logic        r_release;
  logic [31:0] r_result;
  logic [3:0]  r_dest_out;
  logic [3:0]  r_flags;

  logic               w_is_signed;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [63:0]        w_acc_next;
  logic               w_last;
  logic               w_skip;
  logic signed [63:0] w_prod;
  logic [3:0]         w_flags;

  assign w_is_signed = (mul_type == MUL_SR) || (mul_type == MUL_SI);
  assign w_a_mag     = (w_is_signed && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign w_b_mag     = (w_is_signed && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == LAST_ITER) || (r_mplier[31:1] == 31'd0);
  assign w_skip = (w_b_mag == 32'd0);
`else
  assign w_last = (r_cnt == LAST_ITER);
  assign w_skip = 1'b0;
`endif

  // Accumulator always holds the magnitude product; sign is restored here.
  assign w_prod = r_sign ? -$signed(r_acc) : $signed(r_acc);

  always_comb begin
    w_flags = 4'b0000;
    if (r_signed) begin
      w_flags[FLAG_N] = w_prod[31];
      w_flags[FLAG_Z] = (w_prod[31:0] == 32'd0);
      w_flags[FLAG_C] = (r_acc[63:32] != 32'd0);
      w_flags[FLAG_V] = (w_prod != $signed({{32{w_prod[31]}}, w_prod[31:0]}));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_signed   <= 1'b0;
      r_dest     <= '0;
      r_release  <= 1'b0;
      r_result   <= '0;
      r_dest_out <= '0;
      r_flags    <= '0;
    end else begin
      // Result outputs are zero except in the single release cycle.
      r_release  <= 1'b0;
      r_result   <= '0;
      r_dest_out <= '0;
      r_flags    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (mul_start) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_sign   <= w_is_signed && (operand_a[31] ^ operand_b[31]);
            r_signed <= w_is_signed;
            r_dest   <= dest_reg;
            r_state  <= w_skip ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_release  <= 1'b1;
          r_result   <= w_prod[31:0];
          r_dest_out <= r_dest;
          r_flags    <= w_flags;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_busy     = (r_state != ST_IDLE);
  assign mul_release  = r_release;
  assign write_to_reg = r_release;
  assign mul_result   = r_result;
  assign mul_dest     = r_dest_out;
  assign flags_back   = r_flags;

endmodule
